systolic_matmul_nxn: RTL and testbench
======================================

Name: systolic_matmul_nxn

Overview:
Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B.
- Generalises the fixed 2×2 broadcast array: A values travel right and B values travel down through PE registers.
- Input skewing is internal, so the producer streams unskewed data.
- A start/done FSM controls each operation, with valid/ready on input and output.
- Sits between the tile loader and the writeback unit.

Parameters:
N, 4, array dimension (N ≥ 2); A, B and C are N×N
DW, 8, operand element width
AW, 2*DW+$clog2(N), accumulator/result element width (must not be overridden smaller)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin an operation; sampled only in IDLE
busy  out  1  high in states LOAD, DRAIN and DONE
in_valid  in  1  beat k available on a_col/b_row
in_ready  out  1  high only in LOAD
a_col  in  N*DW  column k of A; element i (row i) at bits [i*DW +: DW]
b_row  in  N*DW  row k of B; element j (column j) at bits [j*DW +: DW]
out_valid  out  1  result matrix valid (DONE state)
out_ready  in  1  consumer accepts result
c_flat  out  N*N*AW  C[i][j] at bits [(i*N+j)*AW +: AW]

Behaviour:
- Reset (async, rst=1) has immediate effect:
  - State goes to IDLE; busy, in_ready and out_valid are 0; c_flat is all 0.
  - All skew registers, PE pipes and the beat counter are 0.
- FSM states are IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 → LOAD next cycle.
  - The same edge clears all accumulators and skew/PE pipes and sets beat count to 0.
- LOAD:
  - in_ready=1; a beat is accepted on in_valid & in_ready and the beat count increments.
  - When beat N-1 is accepted → DRAIN.
  - Cycles with in_valid=0 inject zero operands into the skew lines. This keeps A/B alignment, so results are unaffected.
- DRAIN:
  - in_ready=0; zeros are injected; an internal counter runs 2N-1 cycles, then → DONE.
  - out_valid first rises in the cycle 2N cycles after the edge that accepted the last beat (e.g. N=2: 4 cycles).
- DONE:
  - out_valid=1; c_flat is stable and equals the accumulator contents.
  - out_valid & out_ready → IDLE next cycle; out_valid drops.
  - c_flat keeps its last value until the next start clears it.
- Skew:
  - a_col element i passes through i registers before entering PE(i,0).
  - b_row element j passes through j registers before entering PE(0,j).
- PE(i,j) each cycle:
  - acc += a_reg*b_reg (unsigned by default), with products zero-extended to AW.
  - Forwards a_reg right and b_reg down, each with a one-cycle register.
- No overflow is possible for full-scale unsigned inputs at the default AW.
- start asserted outside IDLE is ignored.
- in_valid outside LOAD is ignored.
- out_ready outside DONE is ignored.
- Reset mid-operation aborts it: the partial result is discarded, and no out_valid pulse occurs until a new start completes.

Optional Feature:
Macro SYSTOLIC_SIGNED_MAC_EN.
- Defined: operands are two's-complement; products are sign-extended to AW before accumulation; c_flat is signed.
- Undefined: operands are unsigned and zero-extended (default).
- FSM timing and handshakes are identical in both builds.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], streamed with no gaps:
  - C=[[19,22],[43,50]].
  - out_valid rises 4 cycles after the last beat.
- N=4, A=identity, B[i][j]=i*4+j → C equals B.
- N=4, all operands 255, full-scale unsigned:
  - every C element = 260100 (fits in AW=18).
- N=4, random A/B with in_valid deasserted 1–3 cycles between beats, and out_ready held low 5 cycles in DONE:
  - C matches the reference model.
  - c_flat is stable while out_valid=1 and out_ready=0.
- start pulsed during LOAD/DRAIN → ignored, result unchanged. Two back-to-back operations → second result independent of first (accumulators cleared).
- rst asserted during DRAIN → outputs 0 immediately. New operation then completes with the correct result; SYSTOLIC_SIGNED_MAC_EN build: A=[[-1,2],[3,-4]], B=I → C=A.

Source files
------------

// File: rtl/systolic_matmul_nxn.sv
// Output-stationary N x N systolic matrix multiplier, C = A*B, with internal input skew and a start/done FSM.
// Latency: result valid 2N cycles after the edge that accepts the last of N input beats.
// Backpressure: in_ready only in LOAD (gaps inject zeros); result held in DONE until out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start, busy         begin an operation (sampled in IDLE only); high outside IDLE
//   in_valid, in_ready  beat k handshake: a_col = column k of A, b_row = row k of B
//   a_col, b_row        element i/j at bits [i*DW +: DW]
//   out_valid, out_ready result handshake (DONE state)
//   c_flat              C[i][j] at bits [(i*N+j)*AW +: AW]
// Build option: define SYSTOLIC_SIGNED_MAC_EN for two's-complement operands and signed results.

module systolic_matmul_nxn #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DW-1:0]     a_col,
    input  logic [N*DW-1:0]     b_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*N*AW-1:0]   c_flat
);

    localparam int BW  = $clog2(N);
    localparam int CW  = $clog2(2*N);
    // Skew lines are triangular: row i owns i stages starting at index i*(i-1)/2.
    localparam int SKW = N*(N-1)/2;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [CW-1:0]   drain_q, drain_d;

    logic [DW-1:0]   a_skew_q [SKW];
    logic [DW-1:0]   a_skew_d [SKW];
    logic [DW-1:0]   b_skew_q [SKW];
    logic [DW-1:0]   b_skew_d [SKW];
    logic [DW-1:0]   a_pe_q   [N][N];
    logic [DW-1:0]   a_pe_d   [N][N];
    logic [DW-1:0]   b_pe_q   [N][N];
    logic [DW-1:0]   b_pe_d   [N][N];
    logic [AW-1:0]   acc_q    [N][N];
    logic [AW-1:0]   acc_d    [N][N];

    logic [DW-1:0]   a_in [N];
    logic [DW-1:0]   b_in [N];
    logic            clear;
    logic            accumulate;

    // Product extended to accumulator width.
    function automatic logic [AW-1:0] mac_term(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef SYSTOLIC_SIGNED_MAC_EN
        logic signed [2*DW-1:0] p;
        p = $signed(a) * $signed(b);
        return {{(AW-2*DW){p[2*DW-1]}}, p};
`else
        logic [2*DW-1:0] p;
        p = a * b;
        return {{(AW-2*DW){1'b0}}, p};
`endif
    endfunction

    // ---------------- control FSM ----------------
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        drain_d    = drain_q;
        clear      = 1'b0;
        accumulate = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    clear   = 1'b1;
                    beat_d  = '0;
                    drain_d = '0;
                end
            end
            S_LOAD: begin
                accumulate = 1'b1;
                if (in_valid) begin
                    if (beat_q == BW'(N-1)) begin
                        state_d = S_DRAIN;
                        beat_d  = '0;
                        drain_d = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Last product lands 2N-1 edges after the final beat; DONE follows one edge later.
                accumulate = 1'b1;
                if (drain_q == CW'(2*N-1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DONE);

    // ---------------- datapath ----------------
    always_comb begin
        // Anything other than an accepted beat feeds zeros, keeping A/B wavefronts aligned.
        for (int i = 0; i < N; i++) begin
            a_in[i] = (state_q == S_LOAD && in_valid) ? a_col[i*DW +: DW] : '0;
            b_in[i] = (state_q == S_LOAD && in_valid) ? b_row[i*DW +: DW] : '0;
        end

        for (int k = 0; k < SKW; k++) begin
            a_skew_d[k] = '0;
            b_skew_d[k] = '0;
        end
        for (int i = 1; i < N; i++) begin
            a_skew_d[i*(i-1)/2] = a_in[i];
            b_skew_d[i*(i-1)/2] = b_in[i];
            for (int s = 1; s < i; s++) begin
                a_skew_d[i*(i-1)/2 + s] = a_skew_q[i*(i-1)/2 + s - 1];
                b_skew_d[i*(i-1)/2 + s] = b_skew_q[i*(i-1)/2 + s - 1];
            end
        end

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                // A enters from the left edge, B from the top edge.
                if (j == 0) begin
                    if (i == 0) a_pe_d[i][j] = a_in[0];
                    else        a_pe_d[i][j] = a_skew_q[i*(i-1)/2 + i - 1];
                end else begin
                    a_pe_d[i][j] = a_pe_q[i][j-1];
                end
                if (i == 0) begin
                    if (j == 0) b_pe_d[i][j] = b_in[0];
                    else        b_pe_d[i][j] = b_skew_q[j*(j-1)/2 + j - 1];
                end else begin
                    b_pe_d[i][j] = b_pe_q[i-1][j];
                end
                acc_d[i][j] = accumulate ? acc_q[i][j] + mac_term(a_pe_q[i][j], b_pe_q[i][j])
                                         : acc_q[i][j];
            end
        end

        // Starting a new operation wipes every pipe and accumulator on the same edge.
        if (clear) begin
            for (int k = 0; k < SKW; k++) begin
                a_skew_d[k] = '0;
                b_skew_d[k] = '0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pe_d[i][j] = '0;
                    b_pe_d[i][j] = '0;
                    acc_d[i][j]  = '0;
                end
            end
        end
    end

    always_comb begin
        c_flat = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_flat[(i*N+j)*AW +: AW] = acc_q[i][j];
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            drain_q <= '0;
            for (int k = 0; k < SKW; k++) begin
                a_skew_q[k] <= '0;
                b_skew_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= '0;
                    b_pe_q[i][j] <= '0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            drain_q <= drain_d;
            for (int k = 0; k < SKW; k++) begin
                a_skew_q[k] <= a_skew_d[k];
                b_skew_q[k] <= b_skew_d[k];
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pe_q[i][j] <= a_pe_d[i][j];
                    b_pe_q[i][j] <= b_pe_d[i][j];
                    acc_q[i][j]  <= acc_d[i][j];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Self-checking bench for systolic_matmul_nxn (N=4): scoreboard of expected C matrices,
// pushed at start and popped when out_valid rises.
// Honours SYSTOLIC_SIGNED_MAC_EN for the reference model and signed-only checks.

module tb_systolic_matmul_nxn;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2*DW + $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                in_valid;
    logic                in_ready;
    logic [N*DW-1:0]     a_col;
    logic [N*DW-1:0]     b_row;
    logic                out_valid;
    logic                out_ready;
    logic [N*N*AW-1:0]   c_flat;

    always #5 clk = ~clk;

    systolic_matmul_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_col     (a_col),
        .b_row     (b_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_flat    (c_flat)
    );

    logic [DW-1:0]       ma [N][N];
    logic [DW-1:0]       mb [N][N];
    logic [N*N*AW-1:0]   exp_q [$];
    int                  vectors     = 0;
    int                  miscompares = 0;

    function automatic longint opval(input logic [DW-1:0] x);
`ifdef SYSTOLIC_SIGNED_MAC_EN
        return longint'($signed(x));
`else
        return longint'(x);
`endif
    endfunction

    function automatic logic [N*N*AW-1:0] model();
        logic [N*N*AW-1:0] r;
        longint s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += opval(ma[i][k]) * opval(mb[k][j]);
                r[(i*N+j)*AW +: AW] = s[AW-1:0];
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = '0;
                mb[i][j] = '0;
            end
    endtask

    task automatic random_mats();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'($urandom_range(0, 255));
                mb[i][j] = DW'($urandom_range(0, 255));
            end
    endtask

    task automatic start_op();
        exp_q.push_back(model());
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_to_load: in_ready=%b busy=%b, want 1/1", in_ready, busy);
        end
    endtask

    task automatic feed(input int gap_max, input bit glitch);
        for (int k = 0; k < N; k++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(1, gap_max)) begin
                    in_valid = 1'b0;
                    a_col    = $urandom;
                    b_row    = $urandom;
                    step();
                end
            end
            for (int i = 0; i < N; i++) begin
                a_col[i*DW +: DW] = ma[i][k];
                b_row[i*DW +: DW] = mb[k][i];
            end
            in_valid = 1'b1;
            start    = glitch;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL in_ready_load beat %0d: got %b want 1", k, in_ready);
            end
            step();
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    // Called right after the edge that accepted the last beat.
    task automatic collect(input int hold, input bit glitch, input bit chk_lat);
        int                cyc;
        logic [N*N*AW-1:0] snap;
        logic [N*N*AW-1:0] expv;
        cyc = 0;
        if (glitch) begin
            start = 1'b1;
            step();
            start = 1'b0;
            cyc = 1;
        end
        while (out_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, want 1", out_valid, cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (chk_lat) begin
            vectors++;
            if (cyc != 2*N) begin
                miscompares++;
                $display("FAIL latency: got %0d cycles want %0d", cyc, 2*N);
            end
        end
        snap = c_flat;
        repeat (hold) begin
            out_ready = 1'b0;
            step();
            vectors++;
            if (c_flat !== snap || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_stable: out_valid=%b c_flat=%h want 1 and %h", out_valid, c_flat, snap);
            end
        end
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got out_valid with no expected result");
        end else begin
            expv = exp_q.pop_front();
            if (c_flat !== expv) begin
                miscompares++;
                $display("FAIL result: got %h want %h", c_flat, expv);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_to_idle: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic run_op(input int gap_max, input int hold, input bit glitch, input bit chk_lat);
        start_op();
        feed(gap_max, glitch);
        collect(hold, glitch, chk_lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (c_flat !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: c_flat=%h ov=%b ir=%b busy=%b want all 0", c_flat, out_valid, in_ready, busy);
        end
        step();
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b ov=%b want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_small_2x2();
        int want [4];
        int got;
        want = '{19, 22, 43, 50};
        clear_mats();
        ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
        mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
        run_op(0, 0, 1'b0, 1'b1);
        // Result must persist in IDLE after the handshake.
        for (int e = 0; e < 4; e++) begin
            got = int'(c_flat[((e/2)*N + (e%2))*AW +: AW]);
            vectors++;
            if (got != want[e]) begin
                miscompares++;
                $display("FAIL small_c%0d%0d: got %0d want %0d", e/2, e%2, got, want[e]);
            end
        end
    endtask

    task automatic test_identity();
        clear_mats();
        for (int i = 0; i < N; i++) begin
            ma[i][i] = 8'd1;
            for (int j = 0; j < N; j++) mb[i][j] = DW'(i*4 + j);
        end
        run_op(0, 0, 1'b0, 1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                vectors++;
                if (c_flat[(i*N+j)*AW +: AW] !== AW'(i*4 + j)) begin
                    miscompares++;
                    $display("FAIL identity_c%0d%0d: got %0d want %0d", i, j, c_flat[(i*N+j)*AW +: AW], i*4 + j);
                end
            end
    endtask

    task automatic test_full_scale();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 8'hFF;
                mb[i][j] = 8'hFF;
            end
        run_op(0, 0, 1'b0, 1'b1);
`ifndef SYSTOLIC_SIGNED_MAC_EN
        for (int e = 0; e < N*N; e++) begin
            vectors++;
            if (c_flat[e*AW +: AW] !== 18'd260100) begin
                miscompares++;
                $display("FAIL full_scale_e%0d: got %0d want 260100", e, c_flat[e*AW +: AW]);
            end
        end
`endif
    endtask

    task automatic test_random_gaps();
        for (int r = 0; r < 3; r++) begin
            random_mats();
            run_op(3, 5, 1'b0, 1'b1);
        end
    endtask

    task automatic test_start_ignored();
        random_mats();
        run_op(1, 2, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        // in_valid with junk while IDLE must not leak into the next operation.
        in_valid = 1'b1;
        a_col    = $urandom;
        b_row    = $urandom;
        repeat (3) begin
            step();
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL in_ready_idle: got %b want 0", in_ready);
            end
        end
        in_valid = 1'b0;
        random_mats();
        run_op(0, 0, 1'b0, 1'b0);
        random_mats();
        run_op(0, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int seen;
        random_mats();
        start_op();
        feed(0, 1'b0);
        step();
        step();
        rst = 1'b1;
        #2;
        vectors++;
        if (c_flat !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: c_flat=%h ov=%b busy=%b ir=%b want all 0", c_flat, out_valid, busy, in_ready);
        end
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (2*N + 4) begin
            step();
            if (out_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL no_valid_after_abort: got %0d out_valid cycles want 0", seen);
        end
        clear_mats();
        ma[0][0] = 8'hFF; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'hFC;
        for (int i = 0; i < N; i++) mb[i][i] = 8'd1;
        run_op(0, 0, 1'b0, 1'b1);
`ifdef SYSTOLIC_SIGNED_MAC_EN
        vectors++;
        if ($signed(c_flat[0 +: AW]) != -1 || $signed(c_flat[(N+1)*AW +: AW]) != -4) begin
            miscompares++;
            $display("FAIL signed_diag: got %0d,%0d want -1,-4",
                     $signed(c_flat[0 +: AW]), $signed(c_flat[(N+1)*AW +: AW]));
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_col     = '0;
        b_row     = '0;
        test_reset();
        test_small_2x2();
        test_identity();
        test_full_scale();
        test_random_gaps();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
